// File: rtl/tone_pkg.sv
// Shared constants and types for the tone path.
//   PHASE_W      : phase width consumed by the triangle waveform stage
//   DEF_ACC_W    : default phase accumulator width
//   DEF_PRESCALE : default clock cycles per sample tick
//   phase_t      : phase value handed to the triangle stage
package tone_pkg;

  localparam int PHASE_W      = 8;
  localparam int DEF_ACC_W    = 16;
  localparam int DEF_PRESCALE = 4;

  typedef logic [PHASE_W-1:0] phase_t;

endpackage : tone_pkg

// File: rtl/tick_prescaler.sv
// Sample-rate prescaler: counts enabled clock cycles 0..PRESCALE-1 and flags
// the last cycle of each period.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   enable : 1 advances the count, 0 holds it
//   clear  : synchronous restart of the count (wins over enable)
//   tick   : combinational, high while enable=1 and the count is at its last value
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = enable && (r_cnt == LAST);

endmodule : tick_prescaler

// File: rtl/phase_accumulator.sv
// Numerically controlled phase source. Once per sample tick the accumulator
// advances by the active frequency word; new words arrive over a valid/ready
// port and only take effect on a sample boundary (or on a sync restart).
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   enable          : 1 runs the prescaler, 0 freezes the phase
//   sync            : synchronous phase restart (accumulator and prescaler)
//   freq_word       : offered phase increment per tick
//   freq_valid      : freq_word is offered
//   freq_ready      : a word can be accepted (no word pending)
//   subsample_phase : top PHASE_W accumulator bits
//   sample_tick     : one-cycle pulse when a new phase value appears
//   wrap            : one-cycle pulse with sample_tick when the add carried out
module phase_accumulator
  import tone_pkg::*;
#(
  parameter int ACC_W    = DEF_ACC_W,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sync,
  input  logic [ACC_W-1:0] freq_word,
  input  logic             freq_valid,
  output logic             freq_ready,
  output phase_t           subsample_phase,
  output logic             sample_tick,
  output logic             wrap
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_active_freq;
  logic [ACC_W-1:0] r_pending_freq;
  logic             r_pending;
  logic             r_sample_tick;
  logic             r_wrap;

  logic             w_tick;
  logic             w_accept;
  logic [ACC_W:0]   w_sum;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .clear  (sync),
    .tick   (w_tick)
  );

  // Carry out of the top bit is the wrap indication.
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_active_freq};
  assign w_accept = freq_valid && !r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc          <= '0;
      r_active_freq  <= '0;
      // NOTE: the pending word register is reset too, so nothing stale can
      // ever be promoted after reset even though r_pending guards it.
      r_pending_freq <= '0;
      r_pending      <= 1'b0;
      r_sample_tick  <= 1'b0;
      r_wrap         <= 1'b0;
    end else begin
      r_sample_tick <= 1'b0;
      r_wrap        <= 1'b0;

      if (sync) begin
        // Restart beats the tick; a waiting word is applied at once so the
        // restarted phase runs at the newly requested rate.
        r_acc <= '0;
        if (r_pending) begin
          r_active_freq <= r_pending_freq;
          r_pending     <= 1'b0;
        end
      end else if (w_tick) begin
        // The add uses the old active word; a promoted word counts from
        // the next tick.
        {r_wrap, r_acc} <= w_sum;
        r_sample_tick   <= 1'b1;
        if (r_pending) begin
          r_active_freq <= r_pending_freq;
          r_pending     <= 1'b0;
        end
      end

      // Accept only happens with r_pending=0, so it never collides with the
      // promotion above.
      if (w_accept) begin
        r_pending_freq <= freq_word;
        r_pending      <= 1'b1;
      end
    end
  end

  assign freq_ready      = !r_pending;
  assign subsample_phase = r_acc[ACC_W-1 -: PHASE_W];
  assign sample_tick     = r_sample_tick;
  assign wrap            = r_wrap;

endmodule : phase_accumulator
